bcd_serial_adder: RTL and testbench

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_seg7_dec.sv | 33 +++
 rtl/bcd_serial_adder.sv | 129 ++++++++++++
 tb/tb_bcd_serial_adder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder and its seven-segment decoder.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] BCD_MAX   = 5'd9;
  localparam logic [4:0] BCD_ADJ   = 5'd10;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_seg7_dec.sv
// One BCD digit to seven segments, bit 6 = segment a ... bit 0 = segment g.
module bcd_seg7_dec
  import bcd_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  logic [6:0] pat;

  // Patterns are active-low; non-decimal codes show nothing.
  always_comb begin
    pat = SEG_BLANK;
    case (digit)
      4'd0:    pat = 7'b0000001;
      4'd1:    pat = 7'b1001111;
      4'd2:    pat = 7'b0010010;
      4'd3:    pat = 7'b0000110;
      4'd4:    pat = 7'b1001100;
      4'd5:    pat = 7'b0100100;
      4'd6:    pat = 7'b0100000;
      4'd7:    pat = 7'b0001111;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0000100;
      default: pat = SEG_BLANK;
    endcase
  end

  assign seg = SEG_ACTIVE_LOW ? pat : ~pat;

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one decimal digit per clock, LSD first,
// with sticky invalid-digit flag and per-digit seven-segment outputs.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [4*DIGITS-1:0] a_r, b_r;
  logic [3:0]         a_dig, b_dig;
  logic [4:0]         step;
  logic               bad_dig;

  // Decimal digit add: returns {carry_out, digit}; codes above 9 wrap mod 16.
  function automatic logic [4:0] bcd_digit(input logic [3:0] x, input logic [3:0] y,
                                           input logic c);
    logic [4:0] t;
    logic [4:0] u;
    t = {1'b0, x} + {1'b0, y} + {4'b0000, c};
    u = t - BCD_ADJ;
    if (t > BCD_MAX) return {1'b1, u[3:0]};
    else             return {1'b0, t[3:0]};
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     if (idx == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        a_dig = a_r[4*i +: 4];
        b_dig = b_r[4*i +: 4];
      end
    end
    step    = bcd_digit(a_dig, b_dig, carry);
    bad_dig = ({1'b0, a_dig} > BCD_MAX) || ({1'b0, b_dig} > BCD_MAX);
  end

  assign busy = (state_q != IDLE);

  // Operand capture is pure data and needs no reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      a_r <= a;
      b_r <= b;
    end
  end

  // done is registered off the DONE state, so it follows DONE by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      err     <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            carry <= cin;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
            idx   <= '0;
          end
        end
        ADD: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) sum[4*i +: 4] <= step[3:0];
          end
          carry <= step[4];
          if (bad_dig) err <= 1'b1;
          if (idx == LAST) begin
            cout <= step[4];
            idx  <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Decoders watch the registered sum.
  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    bcd_seg7_dec #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_dec (
      .digit(sum[4*g +: 4]),
      .seg  (hex[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed and randomised bench for bcd_serial_adder with a scoreboard queue.
module tb_bcd_serial_adder;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        err;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0;
  logic        busy, done, cout, err;
  logic [15:0] sum;
  logic [27:0] hex;

  logic        start1 = 1'b0, cin1 = 1'b0, busy1, done1, cout1, err1;
  logic [3:0]  a1 = '0, b1 = '0, sum1;
  logic [6:0]  hex1;

  logic        start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8, err8;
  logic [31:0] a8 = '0, b8 = '0, sum8;
  logic [55:0] hex8;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  bcd_serial_adder #(.DIGITS(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err), .hex(hex)
  );

  bcd_serial_adder #(.DIGITS(1), .SEG_ACTIVE_LOW(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .err(err1), .hex(hex1)
  );

  bcd_serial_adder #(.DIGITS(8), .SEG_ACTIVE_LOW(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .err(err8), .hex(hex8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    int x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sum", sum, e.sum);
        check("cout", cout, e.cout);
        check("err", err, e.err);
        check("latency", cyc - e.acc, 5);
      end
    end
  end

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({"drain_", tag}, (n < 40) ? 1 : 0, 1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                        input logic xc, input logic [15:0] es, input logic ec,
                        input logic ee);
    exp_t e;
    e.sum = es; e.cout = ec; e.err = ee; e.acc = cyc + 1;
    start = 1'b1; a = xa; b = xb; cin = xc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check({"busy_", tag}, busy, 1);
    wait_drain(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   dc, acc, s;
    logic got1, got8;
    logic [15:0] xa, xb;
    logic xc;

    // Reset state
    @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_err", err, 0);
    check("rst_hex", hex, {4{7'b0000001}});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("carry_out", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("hex_zero", hex, {4{7'b0000001}});
    run_op("carry_in", 16'h0999, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0);
    run_op("bad_digit", 16'h00A5, 16'h0001, 1'b0, 16'h0106, 1'b0, 1'b1);
    run_op("err_clear", 16'h0004, 16'h0004, 1'b0, 16'h0008, 1'b0, 1'b0);
    check("hex_eight", hex[6:0], 7'b0000000);
    check("hex_upper", hex[27:7], {3{7'b0000001}});
    run_op("digit_f", 16'h000F, 16'h000A, 1'b0, 16'h001F, 1'b0, 1'b1);
    check("hex_blank", hex[6:0], 7'b1111111);
    check("hex_one", hex[13:7], 7'b1001111);

    // Start held through ADD and DONE while operands churn
    dc = done_cnt;
    e.sum = 16'h3333; e.cout = 1'b0; e.err = 1'b0; e.acc = cyc + 1;
    start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    sb.push_back(e);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a = 16'h9999; b = 16'h9999; cin = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    wait_drain("restart");
    repeat (8) @(negedge clk);
    check("restart_one_done", done_cnt - dc, 1);

    // Reset two cycles into ADD
    dc = done_cnt;
    start = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_abort_sum", sum, 16'h0005);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_done", done_cnt - dc, 0);
    run_op("after_abort", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      xa = int2bcd(int'($urandom_range(0, 9999)));
      xb = int2bcd(int'($urandom_range(0, 9999)));
      xc = 1'($urandom_range(0, 1));
      s  = bcd2int(xa) + bcd2int(xb) + int'(xc);
      run_op("random", xa, xb, xc, int2bcd(s % 10000), (s >= 10000) ? 1'b1 : 1'b0, 1'b0);
    end

    // One-digit and eight-digit builds
    start1 = 1'b1; a1 = 4'h4; b1 = 4'h1; cin1 = 1'b0;
    start8 = 1'b1; a8 = 32'h12345678; b8 = 32'h87654321; cin8 = 1'b0;
    acc = cyc + 1;
    @(negedge clk);
    start1 = 1'b0; start8 = 1'b0;
    got1 = 1'b0; got8 = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (done1 && !got1) begin
        got1 = 1'b1;
        check("d1_latency", cyc - acc, 2);
        check("d1_sum", sum1, 4'h5);
        check("d1_cout", cout1, 0);
        check("d1_hex_high", hex1, 7'b1011011);
      end
      if (done8 && !got8) begin
        got8 = 1'b1;
        check("d8_latency", cyc - acc, 9);
        check("d8_sum", sum8, 32'h99999999);
        check("d8_cout", cout8, 0);
        check("d8_err", err8, 0);
      end
      @(negedge clk);
    end
    check("d1_done_seen", got1, 1);
    check("d8_done_seen", got8, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
